// File: rtl/axis_bram_line_pkg.sv
// Shared types and constants for the AXIS <-> BRAM line engine.
package axis_bram_line_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_FILL,
    S_WR_COMMIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_DRAIN,
    S_DONE
  } state_t;

  // Word-slot counter width for the default 36-word line.
  localparam int WORDS_PER_LINE_DEF = 36;
  localparam int CNT_W = $clog2(WORDS_PER_LINE_DEF);

  localparam logic MODE_WR = 1'b1;
  localparam logic MODE_RD = 1'b0;

  // Slot counter width for an arbitrary line size (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_bram_line_engine_if.sv
// AXI-Stream bundle. Handshake: a beat transfers on a rising clk edge where
// tvalid and tready are both high; once tvalid is raised the master holds
// tdata/tlast/tvalid stable until that transfer, and tready may toggle freely.
interface axis_bram_line_engine_if #(
  parameter int WORD_W = 16
);
  logic [WORD_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_bram_line_buf.sv
// One BRAM line held in registers: per-word write, whole-line load,
// word read by slot and whole-line output. Word k sits at bits [k*WORD_W +: WORD_W].
module axis_bram_line_buf #(
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 36,
  parameter int SLOT_W         = 6
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             i_we,
  input  logic [SLOT_W-1:0]                i_slot,
  input  logic [WORD_W-1:0]                i_data,
  input  logic                             i_load,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] i_line,
  output logic [WORD_W-1:0]                o_word,
  output logic [WORD_W*WORDS_PER_LINE-1:0] o_line
);

  logic [WORD_W*WORDS_PER_LINE-1:0] r_line;

  // Whole-line load wins over a single-word write; they never coincide in use.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_line;
    end else if (i_we) begin
      r_line[i_slot*WORD_W +: WORD_W] <= i_data;
    end
  end

  assign o_word = r_line[i_slot*WORD_W +: WORD_W];
  assign o_line = r_line;

endmodule

// File: rtl/axis_bram_line_engine.sv
// Packs stream words into wide BRAM lines (write) or unpacks lines into
// stream words (read) over an inclusive, wrapping line-address range.
module axis_bram_line_engine
  import axis_bram_line_pkg::*;
#(
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 36,
  parameter int ADDR_W         = 12,
  parameter int RD_LAT         = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             i_start,
  input  logic                             i_mode,
  input  logic [ADDR_W-1:0]                i_start_addr,
  input  logic [ADDR_W-1:0]                i_end_addr,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err_tlast,
  axis_bram_line_engine_if.slave           s_axis,
  axis_bram_line_engine_if.master          m_axis,
  output logic                             o_bram_en,
  output logic                             o_bram_we,
  output logic [ADDR_W-1:0]                o_bram_addr,
  output logic [WORD_W*WORDS_PER_LINE-1:0] o_bram_wdata,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] i_bram_rdata,
  output state_t                           o_dbg_state
);

  localparam int CW     = cnt_width(WORDS_PER_LINE);
  localparam int LAT_W  = $clog2(RD_LAT + 1);
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  state_t               r_state, w_next;
  logic [ADDR_W-1:0]    r_addr, r_end, r_addr_hold;
  logic [CW-1:0]        r_wcnt;
  logic [LAT_W-1:0]     r_lat;
  logic                 r_err;
  logic [LINE_W-1:0]    r_wdata_hold;

  logic                 w_last_word, w_last_line, w_lat_end;
  logic                 w_s_hs, w_m_hs;
  logic [WORD_W-1:0]    w_word;
  logic [LINE_W-1:0]    w_line;

  assign w_last_word = (r_wcnt == CW'(WORDS_PER_LINE - 1));
  assign w_last_line = (r_addr == r_end);
  assign w_lat_end   = (r_lat == LAT_W'(RD_LAT - 1));
  assign w_s_hs      = (r_state == S_WR_FILL) && s_axis.tvalid;
  assign w_m_hs      = (r_state == S_RD_DRAIN) && m_axis.tready;

  axis_bram_line_buf #(
    .WORD_W        (WORD_W),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .SLOT_W        (CW)
  ) u_buf (
    .clk   (clk),
    .rstn  (rstn),
    .i_we  (w_s_hs),
    .i_slot(r_wcnt),
    .i_data(s_axis.tdata),
    .i_load((r_state == S_RD_WAIT) && w_lat_end),
    .i_line(i_bram_rdata),
    .o_word(w_word),
    .o_line(w_line)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (i_start) w_next = (i_mode == MODE_WR) ? S_WR_FILL : S_RD_ISSUE;
      S_WR_FILL:   if (w_s_hs && w_last_word) w_next = S_WR_COMMIT;
      S_WR_COMMIT: w_next = w_last_line ? S_DONE : S_WR_FILL;
      S_RD_ISSUE:  w_next = S_RD_WAIT;
      S_RD_WAIT:   if (w_lat_end) w_next = S_RD_DRAIN;
      S_RD_DRAIN:  if (w_m_hs && w_last_word) w_next = w_last_line ? S_DONE : S_RD_ISSUE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Command latch, word/latency counters, line address, tlast error and BRAM hold values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr       <= '0;
      r_end        <= '0;
      r_addr_hold  <= '0;
      r_wcnt       <= '0;
      r_lat        <= '0;
      r_err        <= 1'b0;
      r_wdata_hold <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_addr <= i_start_addr;
          r_end  <= i_end_addr;
          r_wcnt <= '0;
          r_err  <= 1'b0;
        end
        S_WR_FILL: if (w_s_hs) begin
          r_wcnt <= r_wcnt + 1'b1;
          // tlast must appear on the final beat of the final line and nowhere else.
          if (s_axis.tlast != (w_last_word && w_last_line)) r_err <= 1'b1;
        end
        S_WR_COMMIT: begin
          r_addr_hold  <= r_addr;
          r_wdata_hold <= w_line;
          if (!w_last_line) begin
            r_addr <= r_addr + 1'b1;
            r_wcnt <= '0;
          end
        end
        S_RD_ISSUE: begin
          r_addr_hold <= r_addr;
          r_lat       <= '0;
        end
        S_RD_WAIT: begin
          r_lat <= r_lat + 1'b1;
          if (w_lat_end) r_wcnt <= '0;
        end
        S_RD_DRAIN: if (w_m_hs) begin
          r_wcnt <= r_wcnt + 1'b1;
          if (w_last_word && !w_last_line) r_addr <= r_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode directly from state; BRAM address/data hold between accesses.
  assign s_axis.tready = (r_state == S_WR_FILL);
  assign m_axis.tvalid = (r_state == S_RD_DRAIN);
  assign m_axis.tlast  = (r_state == S_RD_DRAIN) && w_last_word && w_last_line;
  assign m_axis.tdata  = (r_state == S_RD_DRAIN) ? w_word : '0;
  assign o_bram_en     = (r_state == S_WR_COMMIT) || (r_state == S_RD_ISSUE);
  assign o_bram_we     = (r_state == S_WR_COMMIT);
  assign o_bram_addr   = o_bram_en ? r_addr : r_addr_hold;
  assign o_bram_wdata  = o_bram_we ? w_line : r_wdata_hold;
  assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done        = (r_state == S_DONE);
  assign o_err_tlast   = r_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_axis_bram_line_engine.sv
module tb_axis_bram_line_engine;
  import axis_bram_line_pkg::*;

  localparam int WORD_W = 16;
  localparam int WPL    = 4;
  localparam int ADDR_W = 3;
  localparam int RD_LAT = 2;
  localparam int LINE_W = WORD_W * WPL;
  localparam int NLINES = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc_g = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  // ---------------- DUT ----------------
  logic               i_start = 1'b0, i_mode = 1'b0;
  logic [ADDR_W-1:0]  i_start_addr = '0, i_end_addr = '0;
  logic               o_busy, o_done, o_err_tlast;
  logic               o_bram_en, o_bram_we;
  logic [ADDR_W-1:0]  o_bram_addr;
  logic [LINE_W-1:0]  o_bram_wdata, bram_rdata;
  state_t             dbg_state;

  axis_bram_line_engine_if #(.WORD_W(WORD_W)) s_if ();
  axis_bram_line_engine_if #(.WORD_W(WORD_W)) m_if ();

  axis_bram_line_engine #(
    .WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_mode(i_mode),
    .i_start_addr(i_start_addr), .i_end_addr(i_end_addr),
    .o_busy(o_busy), .o_done(o_done), .o_err_tlast(o_err_tlast),
    .s_axis(s_if), .m_axis(m_if),
    .o_bram_en(o_bram_en), .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr),
    .o_bram_wdata(o_bram_wdata), .i_bram_rdata(bram_rdata), .o_dbg_state(dbg_state)
  );

  // ---------------- BRAM model ----------------
  logic [LINE_W-1:0] mem     [NLINES];
  logic [LINE_W-1:0] ref_mem [NLINES];
  logic [LINE_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (o_bram_en && o_bram_we) mem[o_bram_addr] <= o_bram_wdata;
    if (o_bram_en) rd_pipe[0] <= mem[o_bram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rdata = rd_pipe[RD_LAT-1];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [WORD_W:0]              exp_q    [$];
  logic [ADDR_W+LINE_W-1:0]     exp_wr_q [$];
  logic [ADDR_W-1:0]            exp_rd_q [$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  int done_cnt = 0, done_cyc = 0, last_we_cyc = 0, last_mhs_cyc = 0;
  int first_tv = -1, first_rdy = -1;
  logic prev_en = 1'b0, stalled = 1'b0;
  logic [WORD_W:0] stall_val;

  // Output monitor: BRAM accesses, stream beats, stall stability, done pulses.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_en = 1'b0;
      stalled = 1'b0;
    end else begin
      if (o_bram_en) begin
        chk("bram_en_single_cycle", prev_en, 1'b0);
        if (o_bram_we) begin
          chk("write_expected", exp_wr_q.size() != 0, 1'b1);
          if (exp_wr_q.size() != 0) chk("bram_write", {o_bram_addr, o_bram_wdata}, exp_wr_q.pop_front());
          last_we_cyc = cyc_g;
        end else begin
          chk("read_expected", exp_rd_q.size() != 0, 1'b1);
          if (exp_rd_q.size() != 0) chk("bram_read_addr", o_bram_addr, exp_rd_q.pop_front());
        end
      end
      prev_en = o_bram_en;
      if (stalled) chk("stall_stable", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, stall_val});
      if (m_if.tvalid && m_if.tready) begin
        chk("stream_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("stream_word", {m_if.tlast, m_if.tdata}, exp_q.pop_front());
        last_mhs_cyc = cyc_g;
      end
      stalled   = m_if.tvalid && !m_if.tready;
      stall_val = {m_if.tlast, m_if.tdata};
      if (m_if.tvalid && first_tv < 0) first_tv = cyc_g;
      if (s_if.tready && first_rdy < 0) first_rdy = cyc_g;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc_g;
      end
    end
  end

  // ---------------- vector table ----------------
  // bad_beat: -1 correct tlast, -2 no tlast at all, >=0 extra tlast on that beat.
  // rdy_mode: 0 always ready/valid, 1 ready pattern 1,0,0,1, 2 random.
  typedef struct {
    logic              mode;
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] ea;
    int                bad_beat;
    int                rdy_mode;
    bit                poke;
    logic              exp_err;
  } vec_t;

  vec_t vecs[8];
  logic [WORD_W-1:0] wbuf [64];

  function automatic logic rdy_pat(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err_tlast, 0);
    chk({tag, "_s_tready"}, s_if.tready, 0);
    chk({tag, "_m_tvalid"}, m_if.tvalid, 0);
    chk({tag, "_m_tlast"}, m_if.tlast, 0);
    chk({tag, "_m_tdata"}, m_if.tdata, 0);
    chk({tag, "_bram_en"}, o_bram_en, 0);
    chk({tag, "_bram_we"}, o_bram_we, 0);
    chk({tag, "_bram_addr"}, o_bram_addr, 0);
    chk({tag, "_bram_wdata"}, o_bram_wdata, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [ADDR_W-1:0] d, a;
    logic [LINE_W-1:0] line;
    int lines, nb, beat, t0, budget, done0;
    bit done_seen, poked;
    d = v.ea - v.sa;
    lines = int'(d) + 1;
    nb = lines * WPL;
    // Expectations come from the bench's own reference memory and stimulus.
    for (int l = 0; l < lines; l++) begin
      a = v.sa + ADDR_W'(l);
      if (v.mode) begin
        for (int k = 0; k < WPL; k++) begin
          wbuf[l*WPL+k] = (idx == 0) ? WORD_W'((k + 1) * 16'h1111) : WORD_W'($urandom);
          line[k*WORD_W +: WORD_W] = wbuf[l*WPL+k];
        end
        exp_wr_q.push_back({a, line});
        ref_mem[a] = line;
      end else begin
        exp_rd_q.push_back(a);
        for (int k = 0; k < WPL; k++)
          exp_q.push_back({(l == lines - 1) && (k == WPL - 1), ref_mem[a][k*WORD_W +: WORD_W]});
      end
    end
    first_tv = -1;
    first_rdy = -1;
    done0 = done_cnt;
    @(posedge clk); #1;
    i_start = 1'b1; i_mode = v.mode; i_start_addr = v.sa; i_end_addr = v.ea;
    t0 = cyc_g;
    @(posedge clk); #1;
    beat = 0; budget = 0; done_seen = 0; poked = 0;
    while (!done_seen && budget < 400) begin
      i_start = 1'b0;
      if (v.mode && beat < nb) begin
        s_if.tvalid = (v.rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_if.tdata  = wbuf[beat];
        s_if.tlast  = (v.bad_beat == -2) ? 1'b0 : ((beat == nb - 1) || (beat == v.bad_beat));
      end else begin
        s_if.tvalid = 1'b0;
      end
      m_if.tready = rdy_pat(v.rdy_mode, cyc_g - t0);
      if (v.poke && !poked && first_tv >= 0) begin
        i_start = 1'b1; i_mode = MODE_WR; i_start_addr = '0; i_end_addr = '0;
        poked = 1;
      end
      @(negedge clk);
      if (cyc_g == t0 + 1) chk("busy_cycle1", o_busy, 1);
      if (s_if.tvalid && s_if.tready) beat++;
      if (o_done) begin
        done_seen = 1;
        chk("busy_low_in_done", o_busy, 0);
      end
      @(posedge clk); #1;
      budget++;
    end
    i_start = 1'b0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; m_if.tready = 1'b0;
    chk("done_seen", done_seen, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - done0, 1);
    chk("err_tlast", o_err_tlast, v.exp_err);
    chk("stream_queue_empty", exp_q.size(), 0);
    chk("write_queue_empty", exp_wr_q.size(), 0);
    chk("read_queue_empty", exp_rd_q.size(), 0);
    if (v.mode) begin
      chk("first_tready_latency", first_rdy - t0, 1);
      chk("done_after_commit", done_cyc - last_we_cyc, 1);
    end else begin
      chk("first_tvalid_latency", first_tv - t0, 2 + RD_LAT);
      chk("done_after_last_beat", done_cyc - last_mhs_cyc, 1);
    end
    exp_q.delete(); exp_wr_q.delete(); exp_rd_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    for (int i = 0; i < NLINES; i++) begin
      ref_mem[i] = {$urandom, $urandom};
      mem[i] = ref_mem[i];
    end
    ref_mem[7] = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    ref_mem[0] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    mem[7] = ref_mem[7];
    mem[0] = ref_mem[0];
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;

    //             mode     sa     ea   bad  rdy poke err
    vecs[0] = '{MODE_WR, 3'd5, 3'd5,  -1,  0,  0, 1'b0};
    vecs[1] = '{MODE_RD, 3'd7, 3'd0,  -1,  0,  0, 1'b0};
    vecs[2] = '{MODE_RD, 3'd5, 3'd5,  -1,  1,  1, 1'b0};
    vecs[3] = '{MODE_WR, 3'd2, 3'd3,   2,  0,  0, 1'b1};
    vecs[4] = '{MODE_WR, 3'd6, 3'd1,  -2,  2,  0, 1'b1};
    vecs[5] = '{MODE_RD, 3'd6, 3'd1,  -1,  2,  0, 1'b0};
    vecs[6] = '{MODE_WR, 3'd0, 3'd0,  -1,  0,  0, 1'b0};
    vecs[7] = '{MODE_RD, 3'd2, 3'd3,  -1,  1,  0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a line: nothing reaches the BRAM.
    @(posedge clk); #1;
    i_start = 1'b1; i_mode = MODE_WR; i_start_addr = 3'd3; i_end_addr = 3'd3;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_if.tvalid = 1'b1; s_if.tdata = WORD_W'($urandom); s_if.tlast = 1'b0;
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_zero("post_reset");
    repeat (4) @(posedge clk);
    #1;
    chk("no_write_after_reset", mem[3], ref_mem[3]);

    for (int i = 6; i < 8; i++) run_vec(i, vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
